// File: rtl/crc32_mon_pkg.sv
// crc32_mon_pkg
// Shared constants and helpers for the AXI-stream CRC-32 monitor:
//   - reflected IEEE 802.3 CRC-32 nibble table (poly EDB88320)
//   - CRC_INIT / CRC_XOROUT
//   - crc32_byte(): one-byte update as two table-driven nibble steps
//   - crc32_rec_t: packed per-packet result record
package crc32_mon_pkg;

    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

    // Record length field is sized for the widest supported counter (LEN_W <= 64);
    // narrower counters are zero-extended into it.
    localparam int REC_LEN_W = 64;

    localparam logic [31:0] CRC_NIB_TABLE [16] = '{
        32'h0000_0000, 32'h1DB7_1064, 32'h3B6E_20C8, 32'h26D9_30AC,
        32'h76DC_4190, 32'h6B6B_51F4, 32'h4DB2_6158, 32'h5005_713C,
        32'hEDB8_8320, 32'hF00F_9344, 32'hD6D6_A3E8, 32'hCB61_B38C,
        32'h9B64_C2B0, 32'h86D3_D2D4, 32'hA00A_E278, 32'hBDBD_F21C
    };

    typedef struct packed {
        logic                 ignored;
        logic [31:0]          index;
        logic [REC_LEN_W-1:0] len;
        logic [31:0]          crc;
    } crc32_rec_t;

    function automatic logic [31:0] crc32_nib(input logic [31:0] c);
        return (c >> 4) ^ CRC_NIB_TABLE[c[3:0]];
    endfunction

    // Reflected CRC: low nibble of the byte is consumed first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        c = crc32_nib(c);
        c = crc32_nib(c);
        return c;
    endfunction

endpackage

// File: rtl/crc32_mon_fifo.sv
// crc32_mon_fifo
// Small synchronous FIFO for result records, combinational read of the head.
// A write while full is legal only together with a read (the freed slot is
// reused in the same cycle); the caller enforces that.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   wr_en, wr_data   push
//   rd_en, rd_data   pop / current head
//   full, empty      status
module crc32_mon_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !rd_en) begin
                count <= count + (AW+1)'(1);
            end else if (!wr_en && rd_en) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/axis_crc32_monitor.sv
// axis_crc32_monitor
// Passive AXI-stream tap: per packet, counts bytes and computes CRC-32
// (reflected IEEE 802.3, init/xorout FFFFFFFF) and queues one result record.
// Optional build macro CRC32_MON_DISPLAY_EN: prints each record push in simulation.
// Ports:
//   clk, rstn                           clock, asynchronous active-low reset
//   s_tready/s_tvalid/s_tdata/s_tkeep/s_tlast   observed stream (inputs only)
//   r_valid/r_ready                     result handshake
//   r_ignored/r_index/r_len/r_crc       head result record
//   overflow                            sticky: a record was dropped (FIFO full)
module axis_crc32_monitor
    import crc32_mon_pkg::*;
#(
    parameter int BYTES      = 1,
    parameter int LEN_W      = 32,
    parameter int MIN_LEN    = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               s_tready,
    input  logic               s_tvalid,
    input  logic [8*BYTES-1:0] s_tdata,
    input  logic [BYTES-1:0]   s_tkeep,
    input  logic               s_tlast,
    output logic               r_valid,
    input  logic               r_ready,
    output logic               r_ignored,
    output logic [31:0]        r_index,
    output logic [LEN_W-1:0]   r_len,
    output logic [31:0]        r_crc,
    output logic               overflow
);

    localparam logic [LEN_W:0] MIN_LEN_X = (LEN_W+1)'(MIN_LEN);

    logic [31:0]      crc_q, crc_nx;
    logic [LEN_W-1:0] len_q, len_nx;
    logic [LEN_W:0]   cnt, len_sum;
    logic [31:0]      idx_q;
    logic             overflow_q;
    logic             beat, close, rec_ignored;
    logic             fifo_full, fifo_empty, pop, push_ok;
    crc32_rec_t       rec_in, rec_rd;
    logic             unused_len_bits;

    assign beat  = s_tvalid & s_tready;
    assign close = beat & s_tlast;

    // Fold enabled lanes in ascending order; disabled lanes are skipped.
    always_comb begin
        crc_nx = crc_q;
        cnt    = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (s_tkeep[i]) begin
                crc_nx = crc32_byte(crc_nx, s_tdata[8*i +: 8]);
                cnt    = cnt + (LEN_W+1)'(1);
            end
        end
        len_sum = {1'b0, len_q} + cnt;
        len_nx  = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
    end

    assign rec_ignored = ({1'b0, len_nx} < MIN_LEN_X);

    always_comb begin
        rec_in.ignored = rec_ignored;
        rec_in.index   = rec_ignored ? 32'h0 : idx_q;
        rec_in.len     = REC_LEN_W'(len_nx);
        rec_in.crc     = crc_nx ^ CRC_XOROUT;
    end

    assign pop     = r_valid & r_ready;
    assign push_ok = close & (~fifo_full | pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc_q      <= CRC_INIT;
            len_q      <= '0;
            idx_q      <= 32'd1;
            overflow_q <= 1'b0;
        end else if (beat) begin
            if (s_tlast) begin
                crc_q <= CRC_INIT;
                len_q <= '0;
                // Index advances even when the record is dropped, so gaps show loss.
                if (!rec_ignored) begin
                    idx_q <= idx_q + 32'd1;
                end
                if (fifo_full && !pop) begin
                    overflow_q <= 1'b1;
                end
            end else begin
                crc_q <= crc_nx;
                len_q <= len_nx;
            end
        end
    end

    crc32_mon_fifo #(
        .W     ($bits(crc32_rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (push_ok),
        .wr_data (rec_in),
        .rd_en   (pop),
        .rd_data (rec_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign r_valid   = ~fifo_empty;
    assign r_ignored = rec_rd.ignored;
    assign r_index   = rec_rd.index;
    assign r_len     = rec_rd.len[LEN_W-1:0];
    assign r_crc     = rec_rd.crc;
    assign overflow  = overflow_q;

    // Upper record length bits are zero whenever LEN_W < REC_LEN_W.
    assign unused_len_bits = ^rec_rd.len;

`ifdef CRC32_MON_DISPLAY_EN
    always @(posedge clk) begin
        if (rstn && close) begin
            if (!push_ok) begin
                $display("stream DROPPED");
            end else if (rec_ignored) begin
                $display("stream (ignored) length=%10d  CRC=%08x", len_nx, rec_in.crc);
            end else begin
                $display("stream %3d       length=%10d  CRC=%08x", idx_q, len_nx, rec_in.crc);
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_crc32_monitor.sv
module tb_axis_crc32_monitor;

    localparam int BYTES      = 4;
    localparam int LEN_W      = 6;
    localparam int MIN_LEN    = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int LMAX       = (1 << LEN_W) - 1;

    logic               clk = 1'b0;
    logic               rstn;
    logic               s_tready, s_tvalid, s_tlast;
    logic [8*BYTES-1:0] s_tdata;
    logic [BYTES-1:0]   s_tkeep;
    logic               r_valid, r_ready, r_ignored, overflow;
    logic [31:0]        r_index, r_crc;
    logic [LEN_W-1:0]   r_len;

    always #5 clk = ~clk;

    axis_crc32_monitor #(
        .BYTES(BYTES), .LEN_W(LEN_W), .MIN_LEN(MIN_LEN), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_tready(s_tready), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .r_valid(r_valid), .r_ready(r_ready), .r_ignored(r_ignored),
        .r_index(r_index), .r_len(r_len), .r_crc(r_crc), .overflow(overflow)
    );

    typedef struct {
        bit        ign;
        bit [31:0] idx;
        bit [31:0] len;
        bit [31:0] crc;
    } rec_t;

    rec_t        m_q[$];
    logic [7:0]  m_pkt[$];
    bit   [31:0] m_next_idx;
    bit          m_ovf;
    int          total = 0;
    int          bad = 0;
    bit          popped;
    rec_t        pop_rec;
    int          rr_policy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bit-serial reference CRC-32 (reflected, init/xorout FFFFFFFF).
    function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    function automatic logic rrv();
        if (rr_policy == 0) return 1'b0;
        if (rr_policy == 1) return 1'b1;
        return 1'($urandom);
    endfunction

    // One clock: check outputs against the model at the negedge, drive inputs,
    // then advance the model by what the coming posedge will do.
    task automatic step(input logic v, input logic rdy, input logic [31:0] d,
                        input logic [3:0] k, input logic l, input logic rr);
        bit   full_b, m_pop;
        rec_t nr, tmp;
        int   n;
        @(negedge clk);
        chk("r_valid", 64'(r_valid), 64'(m_q.size() != 0));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (m_q.size() != 0) begin
            chk("r_ignored", 64'(r_ignored), 64'(m_q[0].ign));
            chk("r_len", 64'(r_len), 64'(m_q[0].len));
            chk("r_crc", 64'(r_crc), 64'(m_q[0].crc));
            if (!m_q[0].ign) chk("r_index", 64'(r_index), 64'(m_q[0].idx));
        end
        popped = r_valid && rr;
        if (popped) begin
            pop_rec.ign = r_ignored;
            pop_rec.idx = r_index;
            pop_rec.len = 32'(r_len);
            pop_rec.crc = r_crc;
        end
        s_tvalid = v; s_tready = rdy; s_tdata = d; s_tkeep = k; s_tlast = l; r_ready = rr;

        full_b = (m_q.size() == FIFO_DEPTH);
        m_pop  = (m_q.size() != 0) && rr;
        if (m_pop) tmp = m_q.pop_front();
        if (v && rdy) begin
            for (int i = 0; i < BYTES; i++) if (k[i]) m_pkt.push_back(d[8*i +: 8]);
            if (l) begin
                n      = m_pkt.size();
                nr.len = (n > LMAX) ? 32'(LMAX) : 32'(n);
                nr.crc = ref_crc(m_pkt);
                nr.ign = (nr.len < 32'(MIN_LEN));
                nr.idx = nr.ign ? 32'h0 : m_next_idx;
                if (!nr.ign) m_next_idx++;
                m_pkt.delete();
                if (!full_b || m_pop) m_q.push_back(nr);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, $urandom, 4'hF, 1'b1, rrv());
    endtask

    // mode 0: full beats, 1: random keep / stalls / gaps, 2: one byte per beat in lane 0
    task automatic send_bytes(input logic [7:0] q[$], input int mode);
        int          pos, n;
        logic [31:0] d;
        logic [3:0]  k;
        logic        l, rdy;
        pos = 0;
        n   = q.size();
        do begin
            d = $urandom;
            k = (mode == 0) ? 4'hF : (mode == 1) ? 4'($urandom) : 4'h1;
            for (int i = 0; i < BYTES; i++) begin
                if (k[i]) begin
                    if (pos < n) begin
                        d[8*i +: 8] = q[pos];
                        pos++;
                    end else begin
                        k[i] = 1'b0;
                    end
                end
            end
            l = (pos == n);
            do begin
                rdy = (mode == 1) ? ($urandom % 4 != 0) : 1'b1;
                step(1'b1, rdy, d, k, l, rrv());
            end while (!rdy);
            if (mode == 1 && $urandom % 4 == 0) idle(1);
        end while (pos < n);
    endtask

    task automatic expect_rec(input string tag, input bit ign, input bit [31:0] idx,
                              input bit [31:0] len, input bit [31:0] crc);
        int n;
        n = 0;
        popped = 1'b0;
        while (!popped && n < 20) begin
            step(1'b0, 1'b0, $urandom, 4'h0, 1'b0, 1'b1);
            n++;
        end
        if (!popped) begin
            chk({tag, ".timeout"}, 64'(0), 64'(1));
        end else begin
            chk({tag, ".ign"}, 64'(pop_rec.ign), 64'(ign));
            chk({tag, ".len"}, 64'(pop_rec.len), 64'(len));
            chk({tag, ".crc"}, 64'(pop_rec.crc), 64'(crc));
            if (!ign) chk({tag, ".idx"}, 64'(pop_rec.idx), 64'(idx));
        end
    endtask

    task automatic do_reset(input bit check_vals);
        @(negedge clk);
        rstn = 1'b0;
        s_tvalid = 1'b0; s_tready = 1'b1; s_tlast = 1'b0; s_tkeep = '0; r_ready = 1'b0;
        m_q.delete();
        m_pkt.delete();
        m_next_idx = 1;
        m_ovf = 1'b0;
        @(negedge clk);
        if (check_vals) begin
            chk("rst.r_valid", 64'(r_valid), 64'(0));
            chk("rst.overflow", 64'(overflow), 64'(0));
            chk("rst.r_ignored", 64'(r_ignored), 64'(0));
            chk("rst.r_index", 64'(r_index), 64'(0));
            chk("rst.r_len", 64'(r_len), 64'(0));
            chk("rst.r_crc", 64'(r_crc), 64'(0));
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] digits[$], zeros[$], q[$];
        bit   [31:0] idx0;
        rstn = 1'b0; s_tvalid = 1'b0; s_tready = 1'b0; s_tdata = '0; s_tkeep = '0;
        s_tlast = 1'b0; r_ready = 1'b0; rr_policy = 0;
        for (int i = 0; i < 9; i++) digits.push_back(8'h31 + 8'(i));
        for (int i = 0; i < 32; i++) zeros.push_back(8'h00);

        do_reset(1'b1);

        // check string, packed four per beat and one per beat
        send_bytes(digits, 0);
        expect_rec("digits_x4", 1'b1, 32'd0, 32'd9, 32'hCBF4_3926);
        send_bytes(digits, 2);
        expect_rec("digits_x1", 1'b1, 32'd0, 32'd9, 32'hCBF4_3926);

        // short packet is ignored and does not consume an index
        do_reset(1'b0);
        q = '{8'h61};
        send_bytes(q, 0);
        expect_rec("a", 1'b1, 32'd0, 32'd1, 32'hE8B7_BE43);
        send_bytes(zeros, 0);
        expect_rec("zeros32", 1'b0, 32'd1, 32'd32, 32'h190A_55AD);

        // empty packet and single zero byte
        q.delete();
        send_bytes(q, 0);
        expect_rec("empty", 1'b1, 32'd0, 32'd0, 32'h0000_0000);
        q = '{8'h00};
        send_bytes(q, 0);
        expect_rec("zero1", 1'b1, 32'd0, 32'd1, 32'hD202_EF8D);

        // overflow: third record dropped, its index still consumed
        do_reset(1'b0);
        rr_policy = 0;
        repeat (3) send_bytes(zeros, 0);
        idle(1);
        chk("ovf_set", 64'(overflow), 64'(1));
        expect_rec("ovf_first", 1'b0, 32'd1, 32'd32, 32'h190A_55AD);
        expect_rec("ovf_second", 1'b0, 32'd2, 32'd32, 32'h190A_55AD);
        idle(2);
        chk("ovf_drained", 64'(r_valid), 64'(0));
        send_bytes(zeros, 0);
        expect_rec("ovf_fourth", 1'b0, 32'd4, 32'd32, 32'h190A_55AD);

        // reset in the middle of a packet discards it and clears overflow
        step(1'b1, 1'b1, $urandom, 4'hF, 1'b0, 1'b0);
        step(1'b1, 1'b1, $urandom, 4'h1, 1'b0, 1'b0);
        do_reset(1'b0);
        send_bytes(digits, 0);
        expect_rec("after_rst", 1'b1, 32'd0, 32'd9, 32'hCBF4_3926);
        chk("ovf_cleared", 64'(overflow), 64'(0));

        // length saturates at 2^LEN_W-1
        q.delete();
        for (int i = 0; i < 70; i++) q.push_back(8'($urandom));
        idx0 = m_next_idx;
        send_bytes(q, 0);
        expect_rec("saturate", 1'b0, idx0, 32'(LMAX), ref_crc(q));

        // random packets, random keep, stalls and consumer back-pressure
        rr_policy = 2;
        for (int p = 0; p < 40; p++) begin
            q.delete();
            for (int i = 0, n = $urandom_range(0, 80); i < n; i++) q.push_back(8'($urandom));
            send_bytes(q, 1);
        end
        rr_policy = 1;
        for (int i = 0; i < 50 && m_q.size() != 0; i++) idle(1);
        idle(2);
        chk("final_empty", 64'(r_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
